// File: rtl/channel_isi_model.sv
// Behavioural channel stage: 4-tap FIR inter-symbol interference model with
// optional LFSR noise, round-half-up scaling and saturation to 8-bit samples.
module channel_isi_model #(
  parameter int          NUM_TAPS  = 4,
  parameter int          DATA_W    = 8,
  parameter int          COEF_W    = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] voltage_level_in,
  input  logic                     voltage_level_in_valid,
  input  logic                     coef_wr,
  input  logic [1:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  input  logic                     noise_en,
  input  logic [2:0]               noise_shift,
  output logic signed [DATA_W-1:0] channel_out,
  output logic                     channel_out_valid
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SUM_W  = PROD_W + 2;
  localparam int Y_W    = SUM_W + 1;

  // Handshake: every cycle with voltage_level_in_valid=1 delivers one symbol;
  // there is no ready. Exactly one channel_out_valid pulse follows each symbol
  // one cycle later, and downstream must take it.
  logic signed [DATA_W-1:0] d [NUM_TAPS];
  logic signed [COEF_W-1:0] c [NUM_TAPS];
  logic [15:0]              lfsr;
  logic signed [7:0]        raw_q;
  logic                     valid_q;

  logic                     lfsr_fb;
  logic signed [PROD_W-1:0] prod [NUM_TAPS];
  logic signed [SUM_W-1:0]  sum;
  logic signed [SUM_W-1:0]  rounded;
  logic signed [7:0]        noise;
  logic signed [Y_W-1:0]    y;
  logic signed [DATA_W-1:0] y_sat;

  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        d[i] <= '0;
        c[i] <= '0;
      end
      c[0]    <= COEF_W'(64);
      lfsr    <= LFSR_SEED;
      raw_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (coef_wr) c[coef_addr] <= coef_wdata;
      valid_q <= voltage_level_in_valid;
      if (voltage_level_in_valid) begin
        d[0] <= voltage_level_in;
        for (int i = 1; i < NUM_TAPS; i++) d[i] <= d[i-1];
        // Noise for this symbol is captured before the LFSR steps.
        raw_q <= lfsr[7:0];
        lfsr  <= {lfsr_fb, lfsr[15:1]};
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      prod[i] = PROD_W'(d[i]) * PROD_W'(c[i]);
      sum     = sum + SUM_W'(prod[i]);
    end
    rounded = (sum + SUM_W'(32)) >>> 6;
    noise   = noise_en ? (raw_q >>> noise_shift) : 8'sd0;
    y       = Y_W'(rounded) + Y_W'(noise);
    if (y > Y_W'(127))       y_sat = DATA_W'(127);
    else if (y < -Y_W'(128)) y_sat = DATA_W'(-128);
    else                     y_sat = y[DATA_W-1:0];
  end

  // Output register holds its last value between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      channel_out       <= '0;
      channel_out_valid <= 1'b0;
    end else begin
      channel_out_valid <= valid_q;
      if (valid_q) channel_out <= y_sat;
    end
  end

endmodule

// File: tb/tb_channel_isi_model.sv
// Directed bench for channel_isi_model: expected samples are queued when a
// symbol is driven and checked when the output strobe appears.
module tb_channel_isi_model;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic signed [7:0] voltage_level_in = '0;
  logic              voltage_level_in_valid = 1'b0;
  logic              coef_wr = 1'b0;
  logic [1:0]        coef_addr = '0;
  logic signed [7:0] coef_wdata = '0;
  logic              noise_en = 1'b0;
  logic [2:0]        noise_shift = '0;
  logic signed [7:0] channel_out;
  logic              channel_out_valid;

  logic [7:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [15:0]       m_lfsr;
  logic signed [7:0] m_raw;

  channel_isi_model dut (
    .clk                    (clk),
    .reset                  (reset),
    .voltage_level_in       (voltage_level_in),
    .voltage_level_in_valid (voltage_level_in_valid),
    .coef_wr                (coef_wr),
    .coef_addr              (coef_addr),
    .coef_wdata             (coef_wdata),
    .noise_en               (noise_en),
    .noise_shift            (noise_shift),
    .channel_out            (channel_out),
    .channel_out_valid      (channel_out_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0d required %0d", tag, $signed(obs), $signed(expv));
    end
  endtask

  // Scoreboard side: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (channel_out_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_strobe: got %0d required no strobe", channel_out);
      end
      if (exp_q.size() > 0) check_eq("channel_out", channel_out, exp_q.pop_front());
    end
  end

  task automatic send(input logic signed [7:0] s, input logic signed [7:0] e);
    voltage_level_in       = s;
    voltage_level_in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    voltage_level_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic write_coef(input logic [1:0] a, input logic signed [7:0] v);
    coef_wr    = 1'b1;
    coef_addr  = a;
    coef_wdata = v;
    @(posedge clk); #1;
    coef_wr = 1'b0;
  endtask

  task automatic do_reset();
    idle(2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic model_step();
    m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  endtask

  initial begin
    idle(2);
    check_eq("reset_out", channel_out, 8'd0);
    check_eq("reset_valid", {7'd0, channel_out_valid}, 8'd0);
    reset = 1'b0;

    // Pass-through with reset taps
    send(40, 40);
    send(-77, -77);
    send(127, 127);
    send(-128, -128);

    // Impulse response
    do_reset();
    write_coef(1, 16);
    write_coef(2, -8);
    send(64, 64);
    send(0, 16);
    send(0, -8);
    send(0, 0);

    // Saturation, both polarities
    do_reset();
    for (int i = 1; i < 4; i++) write_coef(2'(i), 64);
    for (int i = 0; i < 4; i++) send(127, 127);
    do_reset();
    for (int i = 1; i < 4; i++) write_coef(2'(i), 64);
    for (int i = 0; i < 4; i++) send(-128, -128);

    // Round-half-up: +32 -> 1, -32 -> 0
    do_reset();
    write_coef(0, 32);
    send(1, 1);
    send(-1, 0);

    // Coefficient write on the same edge as the sample
    do_reset();
    coef_wr    = 1'b1;
    coef_addr  = 2'd0;
    coef_wdata = 8'sd32;
    send(100, 50);
    coef_wr = 1'b0;

    // Bubbles do not shift the delay line
    do_reset();
    write_coef(1, 64);
    send(10, 10);
    idle(3);
    send(20, 30);

    // Noise against a reference LFSR
    do_reset();
    m_lfsr      = 16'hACE1;
    noise_en    = 1'b1;
    noise_shift = 3'd0;
    for (int i = 0; i < 100; i++) begin
      m_raw = m_lfsr[7:0];
      send(0, m_raw);
      model_step();
    end
    idle(2);
    noise_shift = 3'd7;
    for (int i = 0; i < 100; i++) begin
      m_raw = m_lfsr[7:0];
      send(0, m_raw >>> 7);
      model_step();
    end
    idle(2);
    noise_en = 1'b0;

    // Mid-stream reset drops in-flight samples
    do_reset();
    send(11, 11);
    voltage_level_in       = 22;
    voltage_level_in_valid = 1'b1;
    @(posedge clk); #1;
    reset            = 1'b1;
    voltage_level_in = 33;
    @(posedge clk); #1;
    reset                  = 1'b0;
    voltage_level_in_valid = 1'b0;
    check_eq("midreset_out", channel_out, 8'd0);
    check_eq("midreset_valid", {7'd0, channel_out_valid}, 8'd0);
    send(50, 50);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1);
    idle(2);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain: got %0d pending outputs required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/channel_isi_model.md
# channel_isi_model

Behavioural channel stage placed directly downstream of the TX PAM encoder. It consumes the encoder's signed 8-bit voltage levels and applies a 4-tap FIR to model inter-symbol interference. It optionally adds LFSR-generated pseudo-random noise and emits saturated 8-bit samples with a valid strobe for the RX chain. Tap coefficients are runtime-writable through a simple register port.

## Interface
- NUM_TAPS, 4, FIR length; fixed at 4 for this revision.
- DATA_W, 8, width of input/output samples (signed two's complement).
- COEF_W, 8, coefficient width, signed Q1.6 (64 = 1.0).
- LFSR_SEED, 16'hACE1, noise LFSR reset value; must be nonzero.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- voltage_level_in  in  8  signed sample from PAM encoder.
- voltage_level_in_valid  in  1  sample qualifier; one sample per high cycle.
- coef_wr  in  1  coefficient write strobe.
- coef_addr  in  2  tap index 0..3 (0 = current symbol).
- coef_wdata  in  8  signed Q1.6 coefficient.
- noise_en  in  1  1 = add noise, 0 = noise term forced to 0.
- noise_shift  in  3  arithmetic right-shift applied to raw noise (0 = largest).
- channel_out  out  8  signed saturated channel sample.
- channel_out_valid  out  1  one-cycle strobe per output sample.

## Operation
- Delay line d0..d3 (8-bit signed). On each cycle with voltage_level_in_valid=1: d0<=in, d1<=d0, d2<=d1, d3<=d2. The line holds when valid=0, so bubbles are not symbols.
- Coefficient registers c0..c3. Reset values: c0=64, c1=c2=c3=0 (pass-through). A write updates c[coef_addr] at the clock edge.
- Stage 2 (combinational, registered into the output):
  - products p_i = d_i * c_i, 16-bit signed.
  - sum = Σp_i, 18-bit signed.
  - rounded = (sum + 32) >>> 6, arithmetic.
  - y = rounded + noise, in 19-bit signed.
  - Saturate y to [-128, 127].
- Noise source:
  - 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - Reset value LFSR_SEED.
  - Advances once per accepted input sample, independent of noise_en.
  - raw = signed lfsr[7:0] sampled before the advance; noise = raw >>> noise_shift.
  - noise_en=0 forces noise = 0.
- No backpressure: the downstream stage must accept every channel_out_valid strobe.

## Timing
- Latency: sample accepted at edge T is included in the output registered at edge T+1, visible in cycle T+1 with channel_out_valid=1 for exactly one cycle.
- Throughput: one sample per cycle. Back-to-back valids give back-to-back output strobes.
- Reset (synchronous, checked at the edge):
  - d0..d3 = 0, coefficients to reset values, LFSR = LFSR_SEED.
  - channel_out = 0, channel_out_valid = 0.
  - An in-flight sample is dropped with no strobe.
  - Reset has priority over a coefficient write or input valid in the same cycle.
- Coefficient write with no input valid at edge T: the new value applies to computations from cycle T+1 onward.
- Coefficient write coincident with valid at edge T: that sample uses the new coefficient.
- Outputs hold their last value when no sample is in flight; channel_out_valid=0.
- Saturation clamps; no wrap-around under any input/coefficient combination.
- Rounding is round-half-up: sum=-32 gives 0, sum=32 gives 1.

## Test plan
- Reset pass-through: after reset, drive valid samples 40, -77, 127, -128 back-to-back. Expect outputs 40, -77, 127, -128, each one cycle after input, valid high for 4 cycles.
- Impulse response: write taps {64,16,-8,0}, drive 64 then three zeros. Expect outputs 64, 16, -8, 0.
- Saturation and rounding: set all taps 64, drive four 127s. Expect 127, 127, 127, 127 (sums 127, 254, 381, 508 clamp). Repeat with four -128s: expect -128 clamps from the second sample on. Set tap0=32 and drive 1 then -1: expect 1 then 0.
- Bubbles: taps {64,64,0,0}. Drive 10, three idle cycles, then 20. Expect outputs 10 then 30, with no strobes during the idle cycles.
- Noise: noise_en=1, noise_shift=0, input 0, 100 samples. Outputs must equal a bench LFSR model (seed 16'hACE1) bit-for-bit. With noise_shift=7, every output ∈ {-1, 0}.
- Mid-stream reset: assert reset during continuous traffic. The next cycle shows channel_out_valid=0 and channel_out=0. After release, a sample of 50 produces output 50, confirming the delay line, coefficients and LFSR returned to reset values.
